pmem_burst_responder: RTL

Physical-memory-side responder that terminates the controller end of the cache-line memory interface. It accepts one line request (read or write) held by the controller and waits a programmable access latency. It then streams or absorbs a BEATS-beat burst of DATA_W-bit words, one per cycle, with a per-beat mem_resp strobe. It serves as the backing memory model and burst endpoint behind the cache line adaptor, and as the bench target for cache/adaptor verification.

---
 rtl/pmem_burst_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pmem_burst_responder.sv
// Backing-memory burst responder: accepts one line request, waits a fixed access
// latency, then streams or absorbs BEATS beats with a per-beat mem_resp strobe.
module pmem_burst_responder #(
    parameter int DATA_W      = 64,
    parameter int BEATS       = 4,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_resp,
    output logic                busy,
    output logic                err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = $clog2(DATA_W * BEATS / 8);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LAT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam int WORDS  = DEPTH_LINES * BEATS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    state_t                   state_r;
    logic [IDX_W-1:0]         idx_r;
    logic                     op_read_r;
    logic [BEAT_W-1:0]        beat_cnt_r;
    logic [LAT_W-1:0]         lat_cnt_r;
    logic [DATA_W-1:0]        mem_rdata_r;
    logic                     mem_resp_r;
    logic                     busy_r;
    logic                     err_r;

    logic [DATA_W-1:0]        mem_array [WORDS];
    logic [BEAT_W-1:0]        rd_beat_s;
    logic [IDX_W+BEAT_W-1:0]  rd_addr_s;
    logic [IDX_W+BEAT_W-1:0]  wr_addr_s;
    logic [DATA_W-1:0]        rd_word_s;
    logic                     unused_addr_s;

    // Byte-masked merge of a new beat over the stored beat.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign unused_addr_s = ^{mem_address[ADDR_W-1:OFF_W+IDX_W], mem_address[OFF_W-1:0]};

    // Read-ahead address: the beat to be presented after the next edge.
    always_comb begin
        rd_beat_s = '0;
        if (state_r == ST_BURST) begin
            rd_beat_s = beat_cnt_r + BEAT_W'(1);
        end else begin
            rd_beat_s = '0;
        end
        rd_addr_s = {idx_r, rd_beat_s};
        wr_addr_s = {idx_r, beat_cnt_r};
        rd_word_s = mem_array[rd_addr_s];
    end

    // Storage array; intentionally not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_BURST && !op_read_r) begin
            mem_array[wr_addr_s] <= merge_bytes(mem_array[wr_addr_s], mem_wdata, mem_byte_enable);
        end
    end

    // Request/latency/burst sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            op_read_r   <= 1'b0;
            beat_cnt_r  <= '0;
            lat_cnt_r   <= '0;
            mem_rdata_r <= '0;
            mem_resp_r  <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_read || mem_write) begin
                        idx_r     <= mem_address[OFF_W +: IDX_W];
                        op_read_r <= mem_read;
                        lat_cnt_r <= LAT_W'(LATENCY - 1);
                        state_r   <= ST_WAIT;
                        busy_r    <= 1'b1;
                        if (mem_read && mem_write) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r == LAT_W'(0)) begin
                        state_r    <= ST_BURST;
                        beat_cnt_r <= '0;
                        mem_resp_r <= 1'b1;
                        if (op_read_r) begin
                            mem_rdata_r <= rd_word_s;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (beat_cnt_r == BEAT_W'(BEATS - 1)) begin
                        state_r    <= ST_TURN;
                        mem_resp_r <= 1'b0;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        if (op_read_r) begin
                            mem_rdata_r <= rd_word_s;
                        end
                    end
                end
                ST_TURN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_resp_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata = mem_rdata_r;
    assign mem_resp  = mem_resp_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule
